// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the generalised vending controller.
//   - coin code constants (COIN_5, COIN_10, COIN_20, COIN_BAD)
//   - controller state enum vm_state_t
//   - coin_units(): coin code -> value in Rs5 units (0 for the invalid code)
// ---------------------------------------------------------------------------
package vending_pkg;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_20  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } vm_state_t;

    // Value of a coin in Rs5 units; the invalid code is worth nothing.
    function automatic logic [2:0] coin_units(input logic [1:0] code);
        logic [2:0] units;
        units = 3'd0;
        case (code)
            COIN_5:  units = 3'd1;
            COIN_10: units = 3'd2;
            COIN_20: units = 3'd4;
            default: units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
// Owns the change countdown. A load captures the amount owed; afterwards one
// coin is paid per cycle, Rs10 first while at least 2 units remain, then Rs5.
// Outputs are decodes of the registered remainder, so the remainder is
// non-zero exactly while change is being paid.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           capture load_value as the amount owed
//   load_value     amount owed, Rs5 units
//   change5        Rs5 coin paid this cycle
//   change10       Rs10 coin paid this cycle
//   done           this cycle pays the final coin
//   rem            amount still owed, Rs5 units
// ---------------------------------------------------------------------------
module vm_change_dispenser #(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_value,
    output logic                change5,
    output logic                change10,
    output logic                done,
    output logic [CREDIT_W-1:0] rem
);

    logic [CREDIT_W-1:0] rem_q;
    logic [CREDIT_W-1:0] rem_d;
    logic                two_or_more;

    assign two_or_more = (rem_q >= CREDIT_W'(2));

    always_comb begin
        rem_d = rem_q;
        if (load) begin
            rem_d = load_value;
        end else if (rem_q != '0) begin
            rem_d = two_or_more ? (rem_q - CREDIT_W'(2)) : (rem_q - CREDIT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign change10 = two_or_more;
    assign change5  = (rem_q == CREDIT_W'(1));
    // Last coin when 1 or 2 units remain.
    assign done     = (rem_q != '0) && (rem_q <= CREDIT_W'(2));
    assign rem      = rem_q;

endmodule

// File: rtl/vending_machine_gen.sv
// ---------------------------------------------------------------------------
// vending_machine_gen
// Parameterised vending controller: NUM_ITEMS items with a packed price table,
// Rs5/Rs10/Rs20 coins, a credit ceiling, cancel/refund and multi-coin change.
// Optional stock tracking is compiled in when macro VM_STOCK_EN is defined.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   item_sel      item index, captured on the first accepted coin
//   coin_valid    single-cycle pulse, one coin present on coin_type
//   coin_type     00=Rs5 01=Rs10 10=Rs20 11=invalid
//   cancel        refund request (acted on in COLLECT only)
//   vend          one-cycle dispense pulse; vend_item is the item (else 0)
//   change5/10    one pulse per returned coin
//   coin_reject   the coin sampled on the previous edge was returned
//   busy          high while vending or paying change
//   credit        credit held, or change still owed while paying change
//   dbg_state     current controller state
//   restock       (VM_STOCK_EN) reload stock of item_sel, ignored while busy
//   sold_out      (VM_STOCK_EN) per-item stock exhausted
// Coin interface: coin_valid has no back-pressure. Every coin pulse is either
// credited or returned, the latter signalled by coin_reject one cycle later.
// All outputs are registers or decodes of registered state.
// ---------------------------------------------------------------------------
module vending_machine_gen
    import vending_pkg::*;
#(
    parameter int                              NUM_ITEMS   = 4,
    parameter int                              IW          = $clog2(NUM_ITEMS),
    parameter int                              CREDIT_W    = 6,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICE_TABLE = {6'd6, 6'd5, 6'd4, 6'd3},
    parameter int                              MAX_CREDIT  = 12
`ifdef VM_STOCK_EN
    ,
    parameter int                              STOCK_INIT  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IW-1:0]        item_sel,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_type,
    input  logic                 cancel,
`ifdef VM_STOCK_EN
    input  logic                 restock,
    output logic [NUM_ITEMS-1:0] sold_out,
`endif
    output logic                 vend,
    output logic [IW-1:0]        vend_item,
    output logic                 change5,
    output logic                 change10,
    output logic                 coin_reject,
    output logic                 busy,
    output logic [CREDIT_W-1:0]  credit,
    output vm_state_t            dbg_state
);

    vm_state_t           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic                reject_q, reject_d;

    logic                chg_load;
    logic [CREDIT_W-1:0] chg_value;
    logic                chg_done;
    logic [CREDIT_W-1:0] chg_rem;

    // Sums are one bit wider than credit so they never wrap.
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   max_ext;
    logic [CREDIT_W:0]   price_sel_in;
    logic [CREDIT_W:0]   price_sel_q;
    logic                coin_bad;
    logic                item_blocked;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [IW-1:0] idx);
        return PRICE_TABLE[idx*CREDIT_W +: CREDIT_W];
    endfunction

    assign coin_val     = (CREDIT_W+1)'(coin_units(coin_type));
    assign coin_sum     = {1'b0, credit_q} + coin_val;
    assign max_ext      = (CREDIT_W+1)'(MAX_CREDIT);
    assign price_sel_in = {1'b0, price_of(item_sel)};
    assign price_sel_q  = {1'b0, price_of(sel_q)};
    assign coin_bad     = (coin_type == COIN_BAD) || (coin_sum > max_ext);

`ifdef VM_STOCK_EN
    localparam int SW = $clog2(STOCK_INIT + 1);

    logic [SW-1:0] stock_q [NUM_ITEMS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= SW'(STOCK_INIT);
            end
        end else if (state_q == S_VEND) begin
            // A sold-out item never reaches VEND, so this cannot underflow.
            stock_q[sel_q] <= stock_q[sel_q] - SW'(1);
        end else if (restock && !busy) begin
            stock_q[item_sel] <= SW'(STOCK_INIT);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign item_blocked = sold_out[item_sel];
`else
    assign item_blocked = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        sel_d     = sel_q;
        reject_d  = 1'b0;
        chg_load  = 1'b0;
        chg_value = '0;

        case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    if (coin_bad || item_blocked) begin
                        reject_d = 1'b1;
                    end else begin
                        sel_d    = item_sel;
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = (coin_sum >= price_sel_in) ? S_VEND : S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    // Cancel wins over a coin arriving in the same cycle.
                    reject_d = coin_valid;
                    credit_d = '0;
                    if (credit_q != '0) begin
                        chg_load  = 1'b1;
                        chg_value = credit_q;
                        state_d   = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (coin_valid) begin
                    if (coin_bad) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        if (coin_sum >= price_sel_q) begin
                            state_d = S_VEND;
                        end
                    end
                end
            end

            S_VEND: begin
                reject_d = coin_valid;
                credit_d = '0;
                if (credit_q != price_of(sel_q)) begin
                    chg_load  = 1'b1;
                    chg_value = credit_q - price_of(sel_q);
                    state_d   = S_CHANGE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CHANGE: begin
                reject_d = coin_valid;
                if (chg_done) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            sel_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
        end
    end

    vm_change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (chg_load),
        .load_value (chg_value),
        .change5    (change5),
        .change10   (change10),
        .done       (chg_done),
        .rem        (chg_rem)
    );

    assign vend        = (state_q == S_VEND);
    assign vend_item   = vend ? sel_q : '0;
    assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign coin_reject = reject_q;
    assign credit      = (state_q == S_CHANGE) ? chg_rem : credit_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
module tb_vending_machine_gen;
    import vending_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [1:0] item_sel;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       cancel;

    logic       vend, change5, change10, coin_reject, busy;
    logic [1:0] vend_item;
    logic [5:0] credit;
    vm_state_t  dbg_state;

    // Second instance with MAX_CREDIT=6, sharing all inputs.
    logic       vend_6, change5_6, change10_6, coin_reject_6, busy_6;
    logic [1:0] vend_item_6;
    logic [5:0] credit_6;
    vm_state_t  dbg_state_6;

`ifdef VM_STOCK_EN
    logic       restock;
    logic [3:0] sold_out, sold_out_6;
`endif

    int checks;
    int errors;

    vending_machine_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .item_sel    (item_sel),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .cancel      (cancel),
`ifdef VM_STOCK_EN
        .restock     (restock),
        .sold_out    (sold_out),
`endif
        .vend        (vend),
        .vend_item   (vend_item),
        .change5     (change5),
        .change10    (change10),
        .coin_reject (coin_reject),
        .busy        (busy),
        .credit      (credit),
        .dbg_state   (dbg_state)
    );

    vending_machine_gen #(.MAX_CREDIT(6)) dut_m6 (
        .clk         (clk),
        .reset_n     (reset_n),
        .item_sel    (item_sel),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .cancel      (cancel),
`ifdef VM_STOCK_EN
        .restock     (restock),
        .sold_out    (sold_out_6),
`endif
        .vend        (vend_6),
        .vend_item   (vend_item_6),
        .change5     (change5_6),
        .change10    (change10_6),
        .coin_reject (coin_reject_6),
        .busy        (busy_6),
        .credit      (credit_6),
        .dbg_state   (dbg_state_6)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic [1:0] t);
        coin_type  = t;
        coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
        coin_type  = 2'b00;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        cancel     = 1'b0;
        item_sel   = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        cancel     = 1'b0;
        item_sel   = 2'd0;
        tick();
        checks++;
        if ({vend, change5, change10, coin_reject, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00000", {vend, change5, change10, coin_reject, busy});
        end
        checks++;
        if (credit !== 6'd0 || dbg_state !== S_IDLE || vend_item !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: credit=%0d state=%0d item=%0d expected 0/IDLE/0", credit, dbg_state, vend_item);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_vend();
        item_sel = 2'd0;
        drive_coin(COIN_5);
        checks++;
        if (credit !== 6'd1 || dbg_state !== S_COLLECT || vend !== 1'b0) begin
            errors++;
            $display("FAIL exact_first_coin: credit=%0d state=%0d vend=%b expected 1/COLLECT/0", credit, dbg_state, vend);
        end
        drive_coin(COIN_10);
        checks++;
        if (vend !== 1'b1 || vend_item !== 2'd0 || busy !== 1'b1 || credit !== 6'd3) begin
            errors++;
            $display("FAIL exact_vend: vend=%b item=%0d busy=%b credit=%0d expected 1/0/1/3", vend, vend_item, busy, credit);
        end
        tick();
        checks++;
        if ({vend, change5, change10, busy} !== 4'b0 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL exact_after: pulses=%b credit=%0d state=%0d expected 0000/0/IDLE", {vend, change5, change10, busy}, credit, dbg_state);
        end
    endtask

    task automatic test_change5();
        item_sel = 2'd0;
        drive_coin(COIN_10);
        drive_coin(COIN_10);
        checks++;
        if (vend !== 1'b1 || vend_item !== 2'd0) begin
            errors++;
            $display("FAIL chg5_vend: vend=%b item=%0d expected 1/0", vend, vend_item);
        end
        tick();
        checks++;
        if (change5 !== 1'b1 || change10 !== 1'b0 || vend !== 1'b0 || credit !== 6'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL chg5_pulse: c5=%b c10=%b vend=%b credit=%0d busy=%b expected 1/0/0/1/1", change5, change10, vend, credit, busy);
        end
        tick();
        checks++;
        if (change5 !== 1'b0 || busy !== 1'b0 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL chg5_done: c5=%b busy=%b credit=%0d state=%0d expected 0/0/0/IDLE", change5, busy, credit, dbg_state);
        end
    endtask

    task automatic test_change10();
        item_sel = 2'd3;
        drive_coin(COIN_20);
        item_sel = 2'd0; // ignored after the first coin
        checks++;
        if (credit !== 6'd4 || dbg_state !== S_COLLECT) begin
            errors++;
            $display("FAIL chg10_collect: credit=%0d state=%0d expected 4/COLLECT", credit, dbg_state);
        end
        drive_coin(COIN_20);
        checks++;
        if (vend !== 1'b1 || vend_item !== 2'd3 || credit !== 6'd8) begin
            errors++;
            $display("FAIL chg10_vend: vend=%b item=%0d credit=%0d expected 1/3/8", vend, vend_item, credit);
        end
        tick();
        checks++;
        if (change10 !== 1'b1 || change5 !== 1'b0 || credit !== 6'd2) begin
            errors++;
            $display("FAIL chg10_pulse: c10=%b c5=%b credit=%0d expected 1/0/2", change10, change5, credit);
        end
        tick();
        checks++;
        if (change10 !== 1'b0 || change5 !== 1'b0 || dbg_state !== S_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL chg10_done: c10=%b c5=%b state=%0d busy=%b expected 0/0/IDLE/0", change10, change5, dbg_state, busy);
        end
    endtask

    task automatic test_cancel();
        item_sel = 2'd2;
        drive_coin(COIN_10);
        checks++;
        if (credit !== 6'd2 || dbg_state !== S_COLLECT) begin
            errors++;
            $display("FAIL cancel_collect: credit=%0d state=%0d expected 2/COLLECT", credit, dbg_state);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (vend !== 1'b0 || change10 !== 1'b1 || change5 !== 1'b0 || credit !== 6'd2) begin
            errors++;
            $display("FAIL cancel_refund: vend=%b c10=%b c5=%b credit=%0d expected 0/1/0/2", vend, change10, change5, credit);
        end
        tick();
        checks++;
        if (vend !== 1'b0 || change10 !== 1'b0 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL cancel_done: vend=%b c10=%b credit=%0d state=%0d expected 0/0/0/IDLE", vend, change10, credit, dbg_state);
        end
    endtask

    task automatic test_reject();
        // Invalid coin code in IDLE.
        item_sel = 2'd0;
        drive_coin(COIN_BAD);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL rej_bad: rej=%b credit=%0d state=%0d expected 1/0/IDLE", coin_reject, credit, dbg_state);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL rej_pulse_width: rej=%b expected 0", coin_reject);
        end
        // Rs20 on item0 vends at once, one Rs5 of change; Rs5 coin during CHANGE.
        drive_coin(COIN_20);
        checks++;
        if (vend !== 1'b1 || credit !== 6'd4) begin
            errors++;
            $display("FAIL rej_direct_vend: vend=%b credit=%0d expected 1/4", vend, credit);
        end
        tick();
        checks++;
        if (change5 !== 1'b1 || dbg_state !== S_CHANGE) begin
            errors++;
            $display("FAIL rej_in_change: c5=%b state=%0d expected 1/CHANGE", change5, dbg_state);
        end
        drive_coin(COIN_5);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL rej_change_coin: rej=%b credit=%0d state=%0d expected 1/0/IDLE", coin_reject, credit, dbg_state);
        end
        // Ceiling: MAX_CREDIT=6 instance, item3, Rs20 then Rs20.
        apply_reset();
        item_sel = 2'd3;
        drive_coin(COIN_20);
        checks++;
        if (credit_6 !== 6'd4 || dbg_state_6 !== S_COLLECT || coin_reject_6 !== 1'b0) begin
            errors++;
            $display("FAIL rej_max_first: credit=%0d state=%0d rej=%b expected 4/COLLECT/0", credit_6, dbg_state_6, coin_reject_6);
        end
        drive_coin(COIN_20);
        checks++;
        if (coin_reject_6 !== 1'b1 || credit_6 !== 6'd4 || dbg_state_6 !== S_COLLECT || vend_6 !== 1'b0) begin
            errors++;
            $display("FAIL rej_max_over: rej=%b credit=%0d state=%0d vend=%b expected 1/4/COLLECT/0", coin_reject_6, credit_6, dbg_state_6, vend_6);
        end
    endtask

    task automatic test_reset_mid_change();
        apply_reset();
        item_sel = 2'd0;
        drive_coin(COIN_10);
        drive_coin(COIN_20);
        checks++;
        if (vend !== 1'b1 || credit !== 6'd6) begin
            errors++;
            $display("FAIL midrst_vend: vend=%b credit=%0d expected 1/6", vend, credit);
        end
        tick();
        checks++;
        if (change10 !== 1'b1 || credit !== 6'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_change: c10=%b credit=%0d busy=%b expected 1/3/1", change10, credit, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({vend, change5, change10, coin_reject, busy} !== 5'b0 || credit !== 6'd0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL midrst_clear: pulses=%b credit=%0d state=%0d expected 00000/0/IDLE", {vend, change5, change10, coin_reject, busy}, credit, dbg_state);
        end
        tick();
        reset_n = 1'b1;
        tick();
        item_sel = 2'd0;
        drive_coin(COIN_5);
        drive_coin(COIN_10);
        checks++;
        if (vend !== 1'b1 || vend_item !== 2'd0 || credit !== 6'd3) begin
            errors++;
            $display("FAIL midrst_revend: vend=%b item=%0d credit=%0d expected 1/0/3", vend, vend_item, credit);
        end
        tick();
        checks++;
        if (vend !== 1'b0 || change5 !== 1'b0 || change10 !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL midrst_revend_done: vend=%b c5=%b c10=%b state=%0d expected 0/0/0/IDLE", vend, change5, change10, dbg_state);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        item_sel   = 2'd0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        cancel     = 1'b0;
`ifdef VM_STOCK_EN
        restock    = 1'b0;
`endif
        test_reset();
        test_exact_vend();
        test_change5();
        test_change10();
        test_cancel();
        test_reject();
        test_reset_mid_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
